// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory bank between the fetch port (IF) and the load/store port (D).
// Optional build macro MEM_ARB_ROUND_ROBIN_EN swaps D-priority/starvation arbitration for round robin.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic       OWNER_IF = 1'b0;
  localparam logic       OWNER_D  = 1'b1;
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t      state_reg;
  logic [3:0]  lat_cnt_reg;
  logic        owner_reg;
  logic        we_reg;
  logic [15:0] addr_reg;
  logic [15:0] wdata_reg;
  logic        mem_en_reg;
  logic        if_rvalid_reg;
  logic        d_rvalid_reg;
  logic [15:0] if_rdata_reg;
  logic [15:0] d_rdata_reg;
  logic        d_wins;
  logic        grant_window;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_reg;

  // On contention the port that did not own the previous access wins.
  always_comb begin
    d_wins = d_req && (!if_req || (last_owner_reg == OWNER_IF));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_reg <= OWNER_IF;
    end else if (if_gnt) begin
      last_owner_reg <= OWNER_IF;
    end else if (d_gnt) begin
      last_owner_reg <= OWNER_D;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_reg;

  // D has priority until IF has lost STARVE_MAX grants in a row.
  always_comb begin
    d_wins = d_req && (!if_req || (starve_cnt_reg != STARVE_LIM));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (d_gnt && if_req) begin
        if (starve_cnt_reg != STARVE_LIM) begin
          starve_cnt_reg <= starve_cnt_reg + 4'd1;
        end
      end else if (if_gnt || !if_req) begin
        starve_cnt_reg <= '0;
      end
    end
  end
`endif

  // Grants are only offered from IDLE and never while reset is asserted.
  assign grant_window = (state_reg == IDLE) && !reset;
  assign if_gnt       = grant_window && if_req && !d_wins;
  assign d_gnt        = grant_window && d_wins;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      lat_cnt_reg   <= '0;
      owner_reg     <= OWNER_IF;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      mem_en_reg    <= 1'b0;
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (if_gnt || d_gnt) begin
            addr_reg    <= d_wins ? d_addr : if_addr;
            wdata_reg   <= d_wins ? d_wdata : 16'h0000;
            we_reg      <= d_wins && d_we;
            owner_reg   <= d_wins ? OWNER_D : OWNER_IF;
            lat_cnt_reg <= LAT_LOAD;
            mem_en_reg  <= 1'b1;
            state_reg   <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_cnt_reg == 4'd0) begin
            // mem_rdata is valid only in the final access cycle.
            if (!we_reg) begin
              if (owner_reg == OWNER_D) begin
                d_rdata_reg <= mem_rdata;
              end else begin
                if_rdata_reg <= mem_rdata;
              end
            end
            mem_en_reg    <= 1'b0;
            if_rvalid_reg <= (owner_reg == OWNER_IF);
            d_rvalid_reg  <= (owner_reg == OWNER_D);
            state_reg     <= RESP;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if_rvalid_reg <= 1'b0;
          d_rvalid_reg  <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_en_reg && we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign if_rvalid = if_rvalid_reg;
  assign d_rvalid  = d_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign busy      = (state_reg != IDLE);

endmodule
